// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer, full/almost-full and level for async FIFO.
// Define WPTR_FULL_OVF_EN to add the sticky overflow flag (woverflow/woverflow_clr).
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 1
) (
    input  logic                  wclk,
    input  logic                  wrstn,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
`ifdef WPTR_FULL_OVF_EN
    input  logic                  woverflow_clr,
    output logic                  woverflow,
`endif
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel
);
    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - AF_MARGIN);
    logic [ADDR_WIDTH:0] wbin, wbin_next, wgray_next, rbin_s, level_next;
    always_comb begin
        for (int i = 0; i <= ADDR_WIDTH; i++)
            rbin_s[i] = ^(wq2_rptr >> i);
    end
    assign wen        = winc & ~wfull;
    assign waddr      = wbin[ADDR_WIDTH-1:0];
    assign wbin_next  = wbin + (ADDR_WIDTH+1)'(wen);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    // level is measured against the lagging synced read pointer, so it can only over-report
    assign level_next = wbin_next - rbin_s;
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
            walmost_full <= level_next >= AF_TH;
            wlevel       <= level_next;
        end
    end
`ifdef WPTR_FULL_OVF_EN
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn)
            woverflow <= 1'b0;
        else
            woverflow <= (winc & wfull) | (woverflow & ~woverflow_clr);
    end
`endif
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed checks of pointer, full/almost-full, level and wrap
// for ADDR_WIDTH=3, AF_MARGIN=1.
module tb_wptr_full_ctrl;
    logic       wclk = 1'b0;
    logic       wrstn = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] wq2_rptr = 4'b0;
    logic       wen, wfull, walmost_full;
    logic [2:0] waddr;
    logic [3:0] wptr, wlevel;
    int tests = 0;
    int fails = 0;
`ifdef WPTR_FULL_OVF_EN
    logic woverflow_clr = 1'b0;
    logic woverflow;
`endif

    wptr_full_ctrl #(.ADDR_WIDTH(3), .AF_MARGIN(1)) dut (
        .wclk(wclk),
        .wrstn(wrstn),
        .winc(winc),
        .wq2_rptr(wq2_rptr),
`ifdef WPTR_FULL_OVF_EN
        .woverflow_clr(woverflow_clr),
        .woverflow(woverflow),
`endif
        .wen(wen),
        .waddr(waddr),
        .wptr(wptr),
        .wfull(wfull),
        .walmost_full(walmost_full),
        .wlevel(wlevel)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrstn = 1'b0; winc = 1'b1; wq2_rptr = 4'b0;
        tick(); tick();
        tests++; if (waddr !== 3'd0) begin fails++; $display("FAIL reset_waddr got %0d want 0", waddr); end
        tests++; if (wptr !== 4'b0000) begin fails++; $display("FAIL reset_wptr got %b want 0000", wptr); end
        tests++; if (wfull !== 1'b0) begin fails++; $display("FAIL reset_wfull got %b want 0", wfull); end
        tests++; if (walmost_full !== 1'b0) begin fails++; $display("FAIL reset_af got %b want 0", walmost_full); end
        tests++; if (wlevel !== 4'd0) begin fails++; $display("FAIL reset_wlevel got %0d want 0", wlevel); end
        tests++; if (wen !== 1'b1) begin fails++; $display("FAIL reset_wen got %b want 1", wen); end
`ifdef WPTR_FULL_OVF_EN
        tests++; if (woverflow !== 1'b0) begin fails++; $display("FAIL reset_wovf got %b want 0", woverflow); end
`endif
        wrstn = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        wq2_rptr = 4'b0; winc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++; if (waddr !== 3'(i) || wen !== 1'b1) begin fails++; $display("FAIL fill_addr%0d got waddr=%0d wen=%b want %0d/1", i, waddr, wen, i); end
            tick();
            tests++; if (wlevel !== 4'(i + 1)) begin fails++; $display("FAIL fill_level%0d got %0d want %0d", i + 1, wlevel, i + 1); end
            tests++; if (walmost_full !== (i + 1 >= 7)) begin fails++; $display("FAIL fill_af%0d got %b want %b", i + 1, walmost_full, i + 1 >= 7); end
            tests++; if (wfull !== (i + 1 == 8)) begin fails++; $display("FAIL fill_full%0d got %b want %b", i + 1, wfull, i + 1 == 8); end
        end
        tests++; if (wptr !== 4'b1100) begin fails++; $display("FAIL fill_wptr got %b want 1100", wptr); end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (wen !== 1'b0) begin fails++; $display("FAIL ovf_wen%0d got %b want 0", i, wen); end
            tick();
            tests++; if (wptr !== 4'b1100 || wlevel !== 4'd8 || wfull !== 1'b1) begin fails++; $display("FAIL ovf_hold%0d got wptr=%b lvl=%0d full=%b want 1100/8/1", i, wptr, wlevel, wfull); end
`ifdef WPTR_FULL_OVF_EN
            tests++; if (woverflow !== 1'b1) begin fails++; $display("FAIL ovf_flag%0d got %b want 1", i, woverflow); end
`endif
        end
        winc = 1'b0;
`ifdef WPTR_FULL_OVF_EN
        woverflow_clr = 1'b1;
        tick();
        woverflow_clr = 1'b0;
        tests++; if (woverflow !== 1'b0) begin fails++; $display("FAIL ovf_clr got %b want 0", woverflow); end
`endif
    endtask

    task automatic test_drain();
        winc = 1'b0; wq2_rptr = 4'b0010;
        tick();
        tests++; if (wfull !== 1'b0) begin fails++; $display("FAIL drain_full got %b want 0", wfull); end
        tests++; if (wlevel !== 4'd5) begin fails++; $display("FAIL drain_level got %0d want 5", wlevel); end
        tests++; if (walmost_full !== 1'b0) begin fails++; $display("FAIL drain_af got %b want 0", walmost_full); end
        tests++; if (wptr !== 4'b1100) begin fails++; $display("FAIL drain_wptr got %b want 1100", wptr); end
    endtask

    task automatic test_wrap();
        logic [3:0] b = 4'd8;
        logic [3:0] prev;
        logic saw15 = 1'b0, saw16 = 1'b0;
        winc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wq2_rptr = gray(b - 4'd2);
            prev = wptr;
            tick();
            b = b + 4'd1;
            tests++; if (wptr !== gray(b) || wfull !== 1'b0 || wlevel !== 4'd3) begin fails++; $display("FAIL wrap%0d got wptr=%b full=%b lvl=%0d want %b/0/3", i, wptr, wfull, wlevel, gray(b)); end
            tests++; if ($countones(wptr ^ prev) > 1) begin fails++; $display("FAIL wrap_step%0d got %b->%b want <=1 bit change", i, prev, wptr); end
            if (b == 4'd15) begin saw15 = 1'b1; tests++; if (wptr !== 4'b1000) begin fails++; $display("FAIL wrap_b15 got %b want 1000", wptr); end end
            if (b == 4'd0) begin saw16 = 1'b1; tests++; if (wptr !== 4'b0000) begin fails++; $display("FAIL wrap_b16 got %b want 0000", wptr); end end
        end
        tests++; if (!(saw15 && saw16)) begin fails++; $display("FAIL wrap_cover got %b%b want 11", saw15, saw16); end
        winc = 1'b0;
    endtask

    task automatic test_reset_mid();
        wrstn = 1'b0; #1; wrstn = 1'b1;
        wq2_rptr = 4'b0; winc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        tests++; if (wlevel !== 4'd5 || waddr !== 3'd5) begin fails++; $display("FAIL mid_pre got lvl=%0d waddr=%0d want 5/5", wlevel, waddr); end
        #2;
        wrstn = 1'b0;
        #1;
        tests++; if (wptr !== 4'b0 || waddr !== 3'd0 || wlevel !== 4'd0 || wfull !== 1'b0 || walmost_full !== 1'b0) begin
            fails++; $display("FAIL mid_reset got wptr=%b waddr=%0d lvl=%0d full=%b af=%b want all 0", wptr, waddr, wlevel, wfull, walmost_full);
        end
        tests++; if (wen !== 1'b1) begin fails++; $display("FAIL mid_wen got %b want 1", wen); end
        winc = 1'b0;
        tick();
        wrstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
